// File: rtl/multicycle_control_fsm.sv
// Main control unit of the multicycle MIPS datapath: Moore instruction-sequencing FSM,
// ALU decoder and PC-enable logic.
module multicycle_control_fsm #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned FUNCT_W  = 6,
    parameter int unsigned STATE_W  = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [OPCODE_W-1:0] Op,
    input  logic [FUNCT_W-1:0]  Funct,
    input  logic                Zero,
    output logic                IorD,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSrc,
    output logic [2:0]          ALUControl,
    output logic                PCEn,
    output logic [STATE_W-1:0]  State
);

    typedef enum logic [STATE_W-1:0] {
        FETCH   = STATE_W'(0),
        DECODE  = STATE_W'(1),
        MEMADR  = STATE_W'(2),
        MEMRD   = STATE_W'(3),
        MEMWB   = STATE_W'(4),
        MEMWR   = STATE_W'(5),
        EXECUTE = STATE_W'(6),
        ALUWB   = STATE_W'(7),
        BRANCH  = STATE_W'(8),
        ADDIEX  = STATE_W'(9),
        ADDIWB  = STATE_W'(10),
        JUMP    = STATE_W'(11)
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

    localparam logic [FUNCT_W-1:0] F_ADD = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] F_SUB = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] F_AND = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] F_OR  = FUNCT_W'(6'b100101);
    localparam logic [FUNCT_W-1:0] F_SLT = FUNCT_W'(6'b101010);

    state_t     state;
    state_t     next_state;
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic       pc_write, branch;
    logic [1:0] alu_src_b, pc_src, alu_op, alu_op_g;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= FETCH;
        else      state <= next_state;
    end

    // Next-state and Moore control decode
    always_comb begin
        next_state = FETCH;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b01;
                pc_write   = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (Op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (Op == OP_LW)      next_state = MEMRD;
                else if (Op == OP_SW) next_state = MEMWR;
            end
            MEMRD: begin
                iord       = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = ADDIWB;
            end
            ADDIWB: reg_write = 1'b1;
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: next_state = FETCH;
        endcase
    end

    // Everything is held inactive while reset is asserted
    assign IorD     = RST & iord;
    assign MemWrite = RST & mem_write;
    assign IRWrite  = RST & ir_write;
    assign RegDst   = RST & reg_dst;
    assign MemtoReg = RST & mem_to_reg;
    assign RegWrite = RST & reg_write;
    assign ALUSrcA  = RST & alu_src_a;
    assign ALUSrcB  = RST ? alu_src_b : 2'b00;
    assign PCSrc    = RST ? pc_src : 2'b00;
    assign alu_op_g = RST ? alu_op : 2'b00;
    assign PCEn     = RST & (pc_write | (branch & Zero));
    assign State    = state;

    // ALU decoder
    always_comb begin
        ALUControl = 3'b010;
        case (alu_op_g)
            2'b01: ALUControl = 3'b110;
            2'b10: begin
                case (Funct)
                    F_ADD:   ALUControl = 3'b010;
                    F_SUB:   ALUControl = 3'b110;
                    F_AND:   ALUControl = 3'b000;
                    F_OR:    ALUControl = 3'b001;
                    F_SLT:   ALUControl = 3'b111;
                    default: ALUControl = 3'b010;
                endcase
            end
            default: ALUControl = 3'b010;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: an instruction-level model yields the expected
// state walk and control word every cycle; literal checks pin reset, strobes and cycle counts.
module tb_multicycle_control_fsm;

    logic       CLK, RST, Zero;
    logic [5:0] Op, Funct;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    multicycle_control_fsm dut (
        .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc), .ALUControl(ALUControl), .PCEn(PCEn), .State(State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Per-step control word: {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,
    //                         ALUSrcB[1:0],PCSrc[1:0],ALUOp[1:0],PCWrite,Branch}
    logic [14:0] step_ctrl [16];
    int          exp_q[$];
    logic [15:0] rw_mask, mw_mask, pcen_mask, mtr_mask;
    logic [2:0]  alu_in_exec;
    int          cycles;

    initial begin
        for (int i = 0; i < 16; i++) step_ctrl[i] = '0;
        step_ctrl[0]  = 15'b0_0_1_0_0_0_0_01_00_00_1_0;
        step_ctrl[1]  = 15'b0_0_0_0_0_0_0_11_00_00_0_0;
        step_ctrl[2]  = 15'b0_0_0_0_0_0_1_10_00_00_0_0;
        step_ctrl[3]  = 15'b1_0_0_0_0_0_0_00_00_00_0_0;
        step_ctrl[4]  = 15'b0_0_0_0_1_1_0_00_00_00_0_0;
        step_ctrl[5]  = 15'b1_1_0_0_0_0_0_00_00_00_0_0;
        step_ctrl[6]  = 15'b0_0_0_0_0_0_1_00_00_10_0_0;
        step_ctrl[7]  = 15'b0_0_0_1_0_1_0_00_00_00_0_0;
        step_ctrl[8]  = 15'b0_0_0_0_0_0_1_00_01_01_0_1;
        step_ctrl[9]  = 15'b0_0_0_0_0_0_1_10_00_00_0_0;
        step_ctrl[10] = 15'b0_0_0_0_0_1_0_00_00_00_0_0;
        step_ctrl[11] = 15'b0_0_0_0_0_0_0_00_10_00_1_0;
    end

    function automatic logic [2:0] alu_model(input logic [1:0] aop, input logic [5:0] f);
        if (aop == 2'b01) return 3'b110;
        if (aop != 2'b10) return 3'b010;
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // Step list of an instruction class, from the cycle-count rules
    task automatic push_walk(input logic [5:0] op);
        case (op)
            6'b100011: exp_q = '{0, 1, 2, 3, 4};
            6'b101011: exp_q = '{0, 1, 2, 5};
            6'b000000: exp_q = '{0, 1, 6, 7};
            6'b000100: exp_q = '{0, 1, 8};
            6'b001000: exp_q = '{0, 1, 9, 10};
            6'b000010: exp_q = '{0, 1, 11};
            default:   exp_q = '{0, 1};
        endcase
    endtask

    // Every-cycle compare against the model while a walk is outstanding
    always @(negedge CLK) begin
        if (RST && exp_q.size() > 0) begin
            int          s;
            logic [14:0] c;
            logic [18:0] want, got;
            s = exp_q.pop_front();
            c = step_ctrl[s];
            want = {c[14:8], c[7:6], c[5:4], alu_model(c[3:2], Funct), c[1] | (c[0] & Zero)};
            got  = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                    ALUSrcB, PCSrc, ALUControl, PCEn};
            chk("state", 32'(State), 32'(s));
            chk("ctrl", 32'(got), 32'(want));
            rw_mask[State]   |= RegWrite;
            mw_mask[State]   |= MemWrite;
            pcen_mask[State] |= PCEn;
            mtr_mask[State]  |= MemtoReg;
            if (State == 4'd6) alu_in_exec = ALUControl;
            cycles++;
        end
    end

    task automatic wait_walk();
        int budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge CLK);
            #2;
            budget--;
        end
        chk("walk_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Issue one instruction starting in FETCH; returns just after the edge back to FETCH
    task automatic run(input logic [5:0] op, input logic [5:0] f, input logic z);
        Op = op; Funct = f; Zero = z;
        rw_mask = '0; mw_mask = '0; pcen_mask = '0; mtr_mask = '0;
        alu_in_exec = 3'bxxx; cycles = 0;
        push_walk(op);
        wait_walk();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_hold(input int n);
        RST = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            chk("rst_state", 32'(State), 32'd0);
            chk("rst_outs", 32'({IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                                 ALUSrcB, PCSrc, PCEn}), 32'd0);
        end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("rel_state", 32'(State), 32'd0);
        chk("rel_irwrite", 32'(IRWrite), 32'd1);
        chk("rel_pcen", 32'(PCEn), 32'd1);
    endtask

    initial begin
        RST = 1'b0; Op = '0; Funct = '0; Zero = 1'b0;
        rw_mask = '0; mw_mask = '0; pcen_mask = '0; mtr_mask = '0;
        alu_in_exec = '0; cycles = 0;
        reset_hold(3);

        run(6'b100011, 6'd0, 1'b0);                       // lw
        chk("lw_cycles", 32'(cycles), 32'd5);
        chk("lw_regwrite", 32'(rw_mask), 32'h0010);
        chk("lw_memtoreg", 32'(mtr_mask), 32'h0010);

        run(6'b101011, 6'd0, 1'b1);                       // sw
        chk("sw_memwrite", 32'(mw_mask), 32'h0020);
        chk("sw_regwrite", 32'(rw_mask), 32'h0000);

        run(6'b000000, 6'b101010, 1'b0);                  // R-type slt
        chk("r_slt_alu", 32'(alu_in_exec), 32'b111);
        chk("r_regwrite", 32'(rw_mask), 32'h0080);
        chk("r_cycles", 32'(cycles), 32'd4);

        run(6'b000000, 6'b100010, 1'b0);                  // sub
        chk("r_sub_alu", 32'(alu_in_exec), 32'b110);
        run(6'b000000, 6'b100100, 1'b0);                  // and
        chk("r_and_alu", 32'(alu_in_exec), 32'b000);
        run(6'b000000, 6'b100101, 1'b0);                  // or
        chk("r_or_alu", 32'(alu_in_exec), 32'b001);
        run(6'b000000, 6'b111111, 1'b0);                  // unknown funct -> add
        chk("r_unk_alu", 32'(alu_in_exec), 32'b010);

        run(6'b000100, 6'd0, 1'b1);                       // beq taken
        chk("beq_t_pcen", 32'(pcen_mask), 32'h0101);
        chk("beq_cycles", 32'(cycles), 32'd3);
        run(6'b000100, 6'd0, 1'b0);                       // beq not taken
        chk("beq_nt_pcen", 32'(pcen_mask), 32'h0001);

        run(6'b001000, 6'd0, 1'b0);                       // addi
        chk("addi_regwrite", 32'(rw_mask), 32'h0400);
        run(6'b000010, 6'd0, 1'b0);                       // j
        chk("j_pcen", 32'(pcen_mask), 32'h0801);

        run(6'b111111, 6'd0, 1'b1);                       // illegal opcode
        chk("ill_cycles", 32'(cycles), 32'd2);
        chk("ill_strobes", 32'(rw_mask | mw_mask), 32'h0000);

        // lw aborted by reset while in MEMRD
        Op = 6'b100011; Funct = '0; Zero = 1'b0;
        rw_mask = '0; mw_mask = '0; pcen_mask = '0; mtr_mask = '0; cycles = 0;
        exp_q = '{0, 1, 2, 3};
        wait_walk();
        chk("abort_at_memrd", 32'(State), 32'd3);
        RST = 1'b0;
        #1;
        chk("abort_state", 32'(State), 32'd0);
        chk("abort_regwrite", 32'(RegWrite), 32'd0);
        reset_hold(2);
        chk("abort_no_wb", 32'(rw_mask), 32'h0000);

        run(6'b101011, 6'd0, 1'b0);                       // sw after abort
        chk("post_abort_sw", 32'(mw_mask), 32'h0020);
        exp_q = '{0};                                     // back in FETCH
        wait_walk();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

endmodule
